// File: rtl/alarm_display_pio.sv
// Avalon-MM output PIO for the alarm panel display: DATA register with atomic set/clear
// ports and an optional hardware blink engine (enabled by ALARM_DISPLAY_PIO_BLINK_EN).
module alarm_display_pio #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DIV_WIDTH   = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  blink_phase
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    if (DATA_WIDTH < 1 || DATA_WIDTH > 32) begin : g_bad_data_width
        $error("alarm_display_pio: DATA_WIDTH must be 1..32");
    end
    if (DIV_WIDTH < 1 || DIV_WIDTH > 32 || DIV_WIDTH > DATA_WIDTH) begin : g_bad_div_width
        $error("alarm_display_pio: DIV_WIDTH must be 1..32 and <= DATA_WIDTH");
    end

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_q;

    assign wr_en = chipselect && !write_n;

    // Only one address is written per cycle, so set and clear never collide.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data_q <= writedata;
                ADDR_OUTSET:   data_q <= data_q | writedata;
                ADDR_OUTCLEAR: data_q <= data_q & ~writedata;
                default:       data_q <= data_q;
            endcase
        end
    end

`ifdef ALARM_DISPLAY_PIO_BLINK_EN

    localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mask_q;
    logic [DIV_WIDTH-1:0]  period_q;
    logic [DIV_WIDTH-1:0]  cnt_q;
    logic                  phase_q;
    logic                  eng_load;
    logic [DIV_WIDTH-1:0]  eng_load_val;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q   <= '0;
            period_q <= '0;
        end else if (wr_en) begin
            if (address == ADDR_MASK)
                mask_q <= writedata;
            if (address == ADDR_PERIOD)
                period_q <= writedata[DIV_WIDTH-1:0];
        end
    end

    // A PERIOD write takes its new value straight into the counter; a STATUS restart reuses the current one.
    always_comb begin
        eng_load     = 1'b0;
        eng_load_val = period_q;
        if (wr_en && address == ADDR_PERIOD) begin
            eng_load     = 1'b1;
            eng_load_val = writedata[DIV_WIDTH-1:0];
        end else if (wr_en && address == ADDR_STATUS && writedata[0]) begin
            eng_load = 1'b1;
        end
    end

    // Software (re)load wins over a terminal count landing on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (eng_load) begin
            cnt_q   <= eng_load_val;
            phase_q <= 1'b0;
        end else if (period_q == '0) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (cnt_q == '0) begin
            cnt_q   <= period_q;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = data_q;
            ADDR_MASK:   readdata = mask_q;
            ADDR_PERIOD: readdata[DIV_WIDTH-1:0] = period_q;
            ADDR_STATUS: readdata[0] = phase_q;
            default:     readdata = '0;
        endcase
    end

    assign out_port    = data_q & ~(mask_q & {DATA_WIDTH{phase_q}});
    assign blink_phase = phase_q;

`else

    always_comb begin
        readdata = '0;
        if (address == ADDR_DATA)
            readdata = data_q;
    end

    assign out_port    = data_q;
    assign blink_phase = 1'b0;

`endif

endmodule

// File: doc/alarm_display_pio.md
# alarm_display_pio

Parametrised Avalon-MM output PIO for the alarm panel display, successor to the fixed 32-bit display register. Adds atomic bit set/clear ports and a hardware blink engine that periodically blanks a masked subset of output bits, so software can flash alarm digits or LEDs without a timer interrupt. Sits on the system interconnect as a single slave; `out_port` drives the display segment/LED logic directly.

## Interface
- `DATA_WIDTH`, default 32: width of data, mask, `writedata`, `readdata` and `out_port`; 1..32.
- `DIV_WIDTH`, default 24: width of the blink period register and prescaler counter; 1..32, at most `DATA_WIDTH`.
- `RESET_VALUE`, default 0: value of DATA after reset.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset_n` in 1: reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `address` in 3: word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata` in DATA_WIDTH: write data.
- `readdata` out DATA_WIDTH: combinational read data, zero wait states.
- `out_port` out DATA_WIDTH: display drive.
- `blink_phase` out 1: current blink phase; 1 means masked bits are blanked.

## Operation
- Register map (word address):
  - 0 DATA: rw; the output pattern.
  - 1 BLINK_MASK: rw; bits that blink.
  - 2 PERIOD: rw, low DIV_WIDTH bits; upper bits ignored and read 0.
  - 3 STATUS: read bit0 = phase, other bits 0; a write with bit0 = 1 restarts the blink engine.
  - 4 OUTSET: write-only; DATA |= writedata; reads 0.
  - 5 OUTCLEAR: write-only; DATA &= ~writedata; reads 0.
  - 6, 7: reserved; reads 0, writes ignored.
- `out_port` = DATA & ~(BLINK_MASK & {DATA_WIDTH{phase}}). This is a combinational function of registers only.
- Blink engine: down-counter `cnt` (DIV_WIDTH bits) plus `phase` bit.
  - PERIOD == 0: blinking disabled; `cnt` and `phase` are held at 0.
  - PERIOD = P > 0: each cycle, if `cnt == 0` then `cnt <= P` and `phase` toggles; otherwise `cnt` decrements.
  - Result: each phase lasts P+1 cycles.
- A write to PERIOD, or a restart write to STATUS, loads `cnt <= new P` and `phase <= 0`. This write takes priority over a terminal count in the same cycle.
- Reads have no side effects.

## Timing
- Reset values (applied on the edge where `reset_n` is sampled low):
  - DATA = RESET_VALUE.
  - BLINK_MASK = 0, PERIOD = 0, `cnt` = 0, `phase` = 0.
  - Hence `out_port` = RESET_VALUE and `blink_phase` = 0.
- Reset asserted mid-blink forces the reset values on that edge; blinking stays off until PERIOD is rewritten.
- A write accepted at edge N is visible on `out_port` and `readdata` after edge N. Write latency is 1 cycle; there are no wait states.
- `readdata` is combinational from `address` and the registers; read latency is 0.
- Only one register is written per cycle, so OUTSET and OUTCLEAR never collide.
- `cnt` arithmetic is modulo 2^DIV_WIDTH; decrement never occurs at 0, so `cnt` never wraps.
- First phase toggle after a PERIOD write of P at edge N occurs at edge N+P+1.

## Configuration
- `ALARM_DISPLAY_PIO_BLINK_EN` defined:
  - Blink engine, BLINK_MASK, PERIOD and STATUS are built as described.
- Not defined:
  - No counter, mask or period flops are built.
  - Addresses 1–3 read 0 and ignore writes.
  - `blink_phase` is tied to 0 and `out_port` = DATA.
  - DATA, OUTSET and OUTCLEAR are unchanged.

## Test plan
- Reset with RESET_VALUE = 0x0000_00A5, then read all 8 addresses -> `out_port` = 0xA5; address 0 reads 0xA5; all others read 0.
- Write DATA = 0x0000_F0F0, then OUTSET 0x0000_000F, then OUTCLEAR 0x0000_F000 -> `out_port` = 0x0000_00FF, one cycle after the last write.
- BLINK_MASK = 0x0000_000F, PERIOD = 3, DATA = 0xFF:
  - `out_port` alternates 0xFF / 0xF0 every 4 cycles.
  - The first change occurs 4 cycles after the PERIOD write.
  - `blink_phase` tracks the alternation.
- While `phase` = 1, write STATUS = 1 on the same edge as a terminal count -> `phase` = 0 and `cnt` = 3 after that edge; no toggle occurs.
- Write PERIOD = 0 while blinking -> `phase` = 0 on the next cycle and `out_port` = DATA thereafter.
- Build without `ALARM_DISPLAY_PIO_BLINK_EN`, write BLINK_MASK = 0xFFFF and PERIOD = 1 -> reads return 0 and `out_port` equals DATA.
